fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: data widths, reset defaults, the
// fetch queue entry layout and the fetch FSM state encoding.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous flush. The head word is read
// combinationally so an entry written on one edge is visible to the
// consumer in the very next cycle; an empty FIFO presents all zeros.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic do_push;
    logic do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign count    = count_reg;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end. Issues word-aligned fetch requests while
// credits remain, pairs each in-order memory response with the address that
// produced it, and buffers the result for decode. A redirect flushes the
// buffer, moves fetch_pc, and drains responses still in flight for the old
// path before fetching resumes.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,

    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(fq_entry_t);

    fq_state_e       state_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;

    logic            credit_ok;
    logic            req_accept;
    logic            rsp_keep;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   drop_on_redirect;

    logic            addr_empty;
    logic            addr_full;
    logic [CW-1:0]   addr_count;
    logic [XLEN-1:0] rsp_pc;

    fq_entry_t       push_entry;
    fq_entry_t       head_entry;
    logic [EW-1:0]   head_bits;

    // Every issued fetch reserves a queue slot, so buffered plus in-flight
    // never exceeds DEPTH and a response always finds room.
    assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding_reg}) < (CW+1)'(DEPTH);

    assign imem_req_valid = !rst && (state_reg == FQ_RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Responses are kept only on the live path; in DRAIN, or in the redirect
    // cycle itself, they belong to the abandoned path.
    assign rsp_keep = !rst && imem_rsp_valid && (state_reg == FQ_RUN) && !redirect_valid;

    // In-flight requests that will still answer after the redirect cycle.
    assign drop_on_redirect = outstanding_reg - CW'(imem_rsp_valid);

    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
    assign head_entry = fq_entry_t'(head_bits);

    assign instr_valid = !rst && !q_empty;
    assign q_pop       = instr_valid && instr_ready;
    assign instr       = rst ? '0 : head_entry.instr;
    assign instr_pc    = rst ? '0 : head_entry.pc;

    // Addresses of live requests, oldest first; the head names the next response.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_accept),
        .push_data (fetch_pc_reg),
        .pop       (rsp_keep),
        .pop_data  (rsp_pc),
        .empty     (addr_empty),
        .full      (addr_full),
        .count     (addr_count)
    );

    // Instruction buffer presented to decode. A pop in the redirect cycle
    // still completes; everything else is discarded by the flush.
    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (q_pop),
        .pop_data  (head_bits),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // Fetch FSM: fetch_pc, in-flight count and the drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FQ_RUN;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(req_accept) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                // Redirects may arrive in either state; the drain count is
                // simply reloaded from what is still in flight.
                fetch_pc_reg <= word_align(redirect_pc);
                drop_cnt_reg <= drop_on_redirect;
                state_reg    <= (drop_on_redirect != '0) ? FQ_DRAIN : FQ_RUN;
            end else begin
                if (req_accept) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if ((state_reg == FQ_DRAIN) && imem_rsp_valid) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                    if (drop_cnt_reg == CW'(1)) begin
                        state_reg <= FQ_RUN;
                    end
                end
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && q_full && !q_pop));

    a_rsp_has_addr: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && addr_empty));

    a_addr_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_accept && addr_full));

    a_run_tracks_all: assert property (@(posedge clk) disable iff (rst)
        (state_reg == FQ_RUN) |-> (addr_count == outstanding_reg));

    a_drain_tracks_all: assert property (@(posedge clk) disable iff (rst)
        (state_reg == FQ_DRAIN) |-> (drop_cnt_reg == outstanding_reg));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. A fixed-latency in-order memory answers
// the DUT's requests; a queue-level model (buffered entries plus in-flight
// requests tagged live/stale) predicts the outputs every cycle, and literal
// expectations pin the key scenarios.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
    } fly_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    mem_txn_t    mem_q[$];
    fly_t        m_fly[$];
    ent_t        m_q[$];
    logic [31:0] m_pc;

    int          lat;
    logic [31:0] key;
    int          tcyc;
    int          rcyc;
    int          n_checks;
    int          n_fail;

    logic [31:0] dlv_pc[$];
    int          dlv_cyc[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (tcyc %0d, rcyc %0d)",
                     name, act, want, tcyc, rcyc);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int qgeti(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        dlv_pc.delete();
        dlv_cyc.delete();
        req_log.delete();
        req_cyc.delete();
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    // Stimulus inputs other than the memory response are set by the caller.
    task automatic cycle();
        bit          rsp_now;
        logic [31:0] rsp_word;
        bit          stale;
        bit          exp_rv;
        bit          exp_iv;
        bit          acc;
        bit          has_f;
        fly_t        f;

        rsp_now  = 1'b0;
        rsp_word = '0;
        if (rst) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due == tcyc) begin
            rsp_now  = 1'b1;
            rsp_word = mem_q[0].addr ^ key;
            mem_q.delete(0);
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? rsp_word : 32'hDEAD_BEEF;
        #1;

        if (rst) begin
            chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid),    32'd0);
            chk("rst_instr",       instr,               32'd0);
            chk("rst_instr_pc",    instr_pc,            32'd0);
            m_q.delete();
            m_fly.delete();
            m_pc = RESET_PC;
        end else begin
            stale = 1'b0;
            foreach (m_fly[i]) if (!m_fly[i].keep) stale = 1'b1;
            exp_rv = (m_q.size() + m_fly.size() < DEPTH) && !stale && !redirect_valid;
            exp_iv = (m_q.size() > 0);

            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
            if (exp_iv) begin
                chk("instr_pc", instr_pc, m_q[0].pc);
                chk("instr",    instr,    m_q[0].word);
            end

            // Observed transactions, as the DUT performed them.
            if (instr_valid && instr_ready) begin
                dlv_pc.push_back(instr_pc);
                dlv_cyc.push_back(rcyc);
                $display("instr  pc=%08h word=%08h rcyc=%0d", instr_pc, instr, rcyc);
            end
            if (imem_req_valid && imem_req_ready) begin
                req_log.push_back(imem_req_addr);
                req_cyc.push_back(rcyc);
                mem_q.push_back(mem_txn_t'{addr: imem_req_addr, due: tcyc + lat});
            end

            // Advance the model across the coming edge.
            acc = exp_rv && imem_req_ready;
            if (exp_iv && instr_ready) m_q.delete(0);
            has_f = 1'b0;
            f     = fly_t'{addr: 32'h0, keep: 1'b0};
            if (rsp_now && m_fly.size() > 0) begin
                f     = m_fly[0];
                has_f = 1'b1;
                m_fly.delete(0);
            end
            if (redirect_valid) begin
                m_q.delete();
                foreach (m_fly[i]) m_fly[i].keep = 1'b0;
                m_pc = redirect_pc & ~32'd3;
            end else begin
                if (has_f && f.keep) m_q.push_back(ent_t'{pc: f.addr, word: f.addr ^ key});
                if (acc) begin
                    m_fly.push_back(fly_t'{addr: m_pc, keep: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        tcyc++;
        if (!rst) rcyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) cycle();
        rst  = 1'b0;
        rcyc = 0;
        clear_logs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        tcyc           = 0;
        rcyc           = 0;
        lat            = 1;
        key            = 32'h0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_pc           = RESET_PC;
        @(posedge clk);
        #1;

        // Streaming with 1-cycle memory, data equals address.
        lat = 1;
        key = 32'h0;
        do_reset(2);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (8) cycle();
        chk("t1_pc0",   qget(dlv_pc, 0), 32'h0);
        chk("t1_pc1",   qget(dlv_pc, 1), 32'h4);
        chk("t1_pc2",   qget(dlv_pc, 2), 32'h8);
        chk("t1_pc3",   qget(dlv_pc, 3), 32'hC);
        chk("t1_first", 32'(qgeti(dlv_cyc, 0)), 32'd2);
        chk("t1_cyc3",  32'(qgeti(dlv_cyc, 3)), 32'd5);

        // Decode stalled: exactly DEPTH requests, then credit returns on a pop.
        key = 32'h5A5A_0000;
        do_reset(1);
        instr_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_nreq",     32'(req_log.size()), 32'd4);
        chk("t2_req3",     qget(req_log, 3), 32'hC);
        chk("t2_head_pc",  instr_pc, 32'h0);
        chk("t2_head_ins", instr, 32'h5A5A_0000);
        chk("t2_req_low",  32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        cycle();
        chk("t2_req4",     qget(req_log, 4), 32'h10);
        chk("t2_req4_cyc", 32'(qgeti(req_cyc, 4)), 32'd11);
        instr_ready = 1'b1;
        repeat (8) cycle();
        chk("t2_dlv1",     qget(dlv_pc, 1), 32'h4);

        // Latency 3, redirect with two requests in flight.
        lat = 3;
        key = 32'h0F0F_F0F0;
        do_reset(1);
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        repeat (12) cycle();
        chk("t3_req_tgt",  qget(req_log, 2), 32'h100);
        chk("t3_req_cyc",  32'(qgeti(req_cyc, 2)), 32'd5);
        chk("t3_dlv0",     qget(dlv_pc, 0), 32'h100);
        chk("t3_dlv0_cyc", 32'(qgeti(dlv_cyc, 0)), 32'd9);

        // Redirect with pop and response in the same cycle, unaligned
        // target, then a redirect that wraps the address space.
        lat = 1;
        key = 32'h1234_5678;
        do_reset(1);
        repeat (4) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        cycle();
        redirect_valid = 1'b0;
        repeat (4) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        cycle();
        redirect_valid = 1'b0;
        repeat (8) cycle();
        chk("t4_align",    qget(req_log, 4), 32'h200);
        chk("t4_pop_once", qget(dlv_pc, 2), 32'h8);
        chk("t4_no_stale", qget(dlv_pc, 3), 32'h200);
        chk("t4_dlv5",     qget(dlv_pc, 5), 32'h208);
        chk("t4_wrap_req", qget(req_log, 8), 32'hFFFF_FFF8);
        chk("t4_wrap_0",   qget(req_log, 10), 32'h0);
        chk("t4_wrap_dlv", qget(dlv_pc, 6), 32'hFFFF_FFF8);
        chk("t4_wrap_d0",  qget(dlv_pc, 8), 32'h0);

        // Reset mid-stream with three requests in flight.
        lat = 3;
        key = 32'hCAFE_0000;
        do_reset(1);
        repeat (4) cycle();
        clear_logs();
        rst = 1'b1;
        cycle();
        rst  = 1'b0;
        rcyc = 0;
        chk("t5_iv_after", 32'(instr_valid), 32'd0);
        repeat (8) cycle();
        chk("t5_req0",     qget(req_log, 0), RESET_PC);
        chk("t5_req0_cyc", 32'(qgeti(req_cyc, 0)), 32'd0);
        chk("t5_dlv0",     qget(dlv_pc, 0), RESET_PC);
        chk("t5_dlv0_cyc", 32'(qgeti(dlv_cyc, 0)), 32'd4);

        // Mixed backpressure and redirects, checked against the model only.
        lat = 2;
        key = 32'h600D_F00D;
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
